// File: rtl/gfx256_pixel_queue.sv
// Pixel FIFO feeding a single-outstanding renderer: queues pixels, issues one
// write_o pulse per pixel and waits for ack_i. Optional counters: GFX256_PIXQ_STATS_EN.
module gfx256_pixel_queue #(
    parameter int unsigned point_width = 16,
    parameter int unsigned DEPTH       = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  logic [point_width-1:0]   pixel_x_i,
    input  logic [point_width-1:0]   pixel_y_i,
    input  logic [point_width-1:0]   pixel_z_i,
    input  logic [31:0]              color_i,
    input  logic                     valid_i,
    output logic                     ready_o,
    output logic [point_width-1:0]   pixel_x_o,
    output logic [point_width-1:0]   pixel_y_o,
    output logic [point_width-1:0]   pixel_z_o,
    output logic [31:0]              color_o,
    output logic                     write_o,
    input  logic                     ack_i,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     busy_o
`ifdef GFX256_PIXQ_STATS_EN
    ,
    output logic [31:0]              pix_count_o,
    output logic [15:0]              drop_count_o
`endif
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [point_width-1:0] x;
        logic [point_width-1:0] y;
        logic [point_width-1:0] z;
        logic [31:0]            color;
    } pixel_t;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ISSUE    = 2'd1,
        ST_WAIT_ACK = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]   level_q, level_d;
    logic               ready_q, ready_d;
    logic               busy_q, busy_d;
    logic               write_q, write_d;
    pixel_t             out_q, out_d;
    pixel_t             mem_q [DEPTH];
    pixel_t             in_pix_c;
    logic               push_c;
    logic               pop_c;

    assign in_pix_c = {pixel_x_i, pixel_y_i, pixel_z_i, color_i};

    // Handshake decode: flush discards a coincident push and blocks the pop from IDLE
    always_comb begin
        push_c = 1'b0;
        pop_c  = 1'b0;
        if (!flush_i) begin
            push_c = valid_i && ready_q;
            pop_c  = (state_q == ST_IDLE) && (level_q != '0);
        end
    end

    // FSM state register
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; ack_i only matters while waiting for it
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:     if (pop_c) state_d = ST_ISSUE;
            ST_ISSUE:    state_d = ST_WAIT_ACK;
            ST_WAIT_ACK: if (ack_i) state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: head entry captured on pop, write pulse for the ISSUE cycle
    always_comb begin
        out_d   = out_q;
        write_d = 1'b0;
        if (state_d == ST_ISSUE) begin
            write_d = 1'b1;
        end
        if (pop_c) begin
            out_d = mem_q[rd_ptr_q];
        end
    end

    // Pointer and occupancy update
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush_i) begin
            rd_ptr_d = wr_ptr_q;
            level_d  = '0;
        end else begin
            if (push_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop_c)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            level_d = level_q + LVL_W'(push_c) - LVL_W'(pop_c);
        end
        ready_d = (level_d != LVL_W'(DEPTH));
        busy_d  = (level_d != '0) || (state_d != ST_IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            write_q  <= 1'b0;
            out_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
            write_q  <= write_d;
            out_q    <= out_d;
        end
    end

    // Storage array is not reset; pointers define which entries are live
    always_ff @(posedge clk_i) begin
        if (push_c) begin
            mem_q[wr_ptr_q] <= in_pix_c;
        end
    end

    assign ready_o   = ready_q;
    assign busy_o    = busy_q;
    assign write_o   = write_q;
    assign level_o   = level_q;
    assign pixel_x_o = out_q.x;
    assign pixel_y_o = out_q.y;
    assign pixel_z_o = out_q.z;
    assign color_o   = out_q.color;

`ifdef GFX256_PIXQ_STATS_EN
    logic [31:0] pix_count_q, pix_count_d;
    logic [15:0] drop_count_q, drop_count_d;
    logic [16:0] drop_sum_c;

    // Completed renders wrap; flushed entries saturate
    always_comb begin
        pix_count_d  = pix_count_q;
        drop_count_d = drop_count_q;
        drop_sum_c   = 17'(drop_count_q) + 17'(level_q);
        if ((state_q == ST_WAIT_ACK) && ack_i) begin
            pix_count_d = pix_count_q + 32'd1;
        end
        if (flush_i) begin
            drop_count_d = drop_sum_c[16] ? 16'hFFFF : drop_sum_c[15:0];
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            pix_count_q  <= '0;
            drop_count_q <= '0;
        end else begin
            pix_count_q  <= pix_count_d;
            drop_count_q <= drop_count_d;
        end
    end

    assign pix_count_o  = pix_count_q;
    assign drop_count_o = drop_count_q;
`endif

endmodule

// File: tb/tb_gfx256_pixel_queue.sv
// Bench for gfx256_pixel_queue: queue-based reference model checked every cycle,
// directed literal scenarios, then a randomized 1000-pixel stream.
module tb_gfx256_pixel_queue;

    localparam int unsigned PW    = 16;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned LVL_W = 5;

    logic             clk = 1'b0;
    logic             rst_ni, flush_i, valid_i, ack_i;
    logic [PW-1:0]    pixel_x_i, pixel_y_i, pixel_z_i;
    logic [31:0]      color_i;
    logic             ready_o, write_o, busy_o;
    logic [PW-1:0]    pixel_x_o, pixel_y_o, pixel_z_o;
    logic [31:0]      color_o;
    logic [LVL_W-1:0] level_o;
`ifdef GFX256_PIXQ_STATS_EN
    logic [31:0]      pix_count_o;
    logic [15:0]      drop_count_o;
`endif

    always #5 clk = ~clk;

    gfx256_pixel_queue #(.point_width(PW), .DEPTH(DEPTH)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush_i),
        .pixel_x_i(pixel_x_i), .pixel_y_i(pixel_y_i), .pixel_z_i(pixel_z_i),
        .color_i(color_i), .valid_i(valid_i), .ready_o(ready_o),
        .pixel_x_o(pixel_x_o), .pixel_y_o(pixel_y_o), .pixel_z_o(pixel_z_o),
        .color_o(color_o), .write_o(write_o), .ack_i(ack_i),
        .level_o(level_o), .busy_o(busy_o)
`ifdef GFX256_PIXQ_STATS_EN
        , .pix_count_o(pix_count_o), .drop_count_o(drop_count_o)
`endif
    );

    typedef struct { logic [15:0] x; logic [15:0] y; logic [15:0] z; logic [31:0] c; } pix_t;

    int          n_chk = 0;
    int          n_fail = 0;
    bit          chk_en = 0;
    bit          auto_ack = 0;
    bit          ack_pend = 0;
    int          ack_cd = 0;
    logic [15:0] seen[$];

    // Reference model: a queue of waiting pixels plus the one being rendered.
    // inflight: 0 none, 1 request cycle, 2 waiting for completion.
    pix_t        mq[$];
    int          inflight = 0;
    pix_t        m_cur = '{16'd0, 16'd0, 16'd0, 32'd0};
    int unsigned m_pix = 0;
    int unsigned m_drop = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin : model
        bit   acc, pop;
        pix_t np;
        if (!rst_ni) begin
            mq.delete();
            inflight = 0;
            m_cur    = '{16'd0, 16'd0, 16'd0, 32'd0};
            m_pix    = 0;
            m_drop   = 0;
        end else begin
            acc = valid_i && !flush_i && (mq.size() < DEPTH);
            pop = (inflight == 0) && (mq.size() > 0) && !flush_i;
            if (inflight == 2 && ack_i) begin
                inflight = 0;
                m_pix++;
            end else if (inflight == 1) begin
                inflight = 2;
            end
            if (pop) begin
                m_cur    = mq.pop_front();
                inflight = 1;
            end
            if (flush_i) begin
                m_drop = (m_drop + mq.size() > 65535) ? 65535 : m_drop + mq.size();
                mq.delete();
            end
            if (acc) begin
                np = '{pixel_x_i, pixel_y_i, pixel_z_i, color_i};
                mq.push_back(np);
            end
        end
    end

    always @(negedge clk) begin : compare
        if (chk_en) begin
            chk("ready", 64'(ready_o), 64'(mq.size() != DEPTH));
            chk("level", 64'(level_o), 64'(mq.size()));
            chk("write", 64'(write_o), 64'(inflight == 1));
            chk("busy",  64'(busy_o),  64'(mq.size() != 0 || inflight != 0));
            chk("px",    64'(pixel_x_o), 64'(m_cur.x));
            chk("py",    64'(pixel_y_o), 64'(m_cur.y));
            chk("pz",    64'(pixel_z_o), 64'(m_cur.z));
            chk("color", 64'(color_o),   64'(m_cur.c));
`ifdef GFX256_PIXQ_STATS_EN
            chk("pix_count",  64'(pix_count_o),  64'(m_pix));
            chk("drop_count", 64'(drop_count_o), 64'(m_drop));
`endif
        end
    end

    // Renderer stand-in: acks 0..10 cycles into the wait after each request
    task automatic drive_ack();
        if (auto_ack) begin
            ack_i = 1'b0;
            if (ack_pend) begin
                if (ack_cd == 0) begin
                    ack_i    = 1'b1;
                    ack_pend = 0;
                end else begin
                    ack_cd--;
                end
            end
            if (write_o) begin
                ack_pend = 1;
                ack_cd   = $urandom_range(0, 10);
            end
        end
    endtask

    task automatic tick();
        drive_ack();
        @(posedge clk);
        @(negedge clk);
        if (write_o) seen.push_back(pixel_x_o);
    endtask

    task automatic set_pix(input logic [15:0] x, input logic [15:0] y,
                           input logic [15:0] z, input logic [31:0] c);
        pixel_x_i = x; pixel_y_i = y; pixel_z_i = z; color_i = c;
    endtask

    task automatic push_n(input int n, input int base);
        for (int i = 0; i < n; i++) begin
            valid_i = 1'b1;
            set_pix(16'(base + i), 16'(i), 16'(i * 3), 32'($urandom));
            tick();
        end
        valid_i = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation did not finish, n_fail %0d", n_fail);
        $fatal(1);
    end

    initial begin : stim
        int base_cnt, acc, cyc, mism;
        logic [15:0] sent[$];
        rst_ni = 1'b0; flush_i = 1'b0; valid_i = 1'b0; ack_i = 1'b0;
        set_pix(16'd0, 16'd0, 16'd0, 32'd0);
        @(negedge clk);
        tick();
        chk_en = 1;
        tick();
        chk("rst_ready", 64'(ready_o), 64'd1);
        chk("rst_level", 64'(level_o), 64'd0);
        chk("rst_busy",  64'(busy_o),  64'd0);
        chk("rst_write", 64'(write_o), 64'd0);
        rst_ni = 1'b1;

        // Single pixel latency and hold
        valid_i = 1'b1;
        set_pix(16'd5, 16'd7, 16'h1234, 32'hFF00FF00);
        tick();
        valid_i = 1'b0;
        chk("sp_level", 64'(level_o), 64'd1);
        chk("sp_nowrite", 64'(write_o), 64'd0);
        tick();
        chk("sp_write", 64'(write_o), 64'd1);
        chk("sp_x", 64'(pixel_x_o), 64'd5);
        chk("sp_y", 64'(pixel_y_o), 64'd7);
        chk("sp_z", 64'(pixel_z_o), 64'h1234);
        chk("sp_color", 64'(color_o), 64'hFF00FF00);
        run(3);
        chk("sp_hold_write", 64'(write_o), 64'd0);
        chk("sp_hold_color", 64'(color_o), 64'hFF00FF00);
        chk("sp_hold_busy", 64'(busy_o), 64'd1);
        ack_i = 1'b1;
        tick();
        ack_i = 1'b0;
        chk("sp_busy_fall", 64'(busy_o), 64'd0);

        // Fill with renderer stalled, reject extra pushes, drain in order
        seen.delete();
        push_n(17, 0);
        chk("fill_level", 64'(level_o), 64'd16);
        chk("fill_ready", 64'(ready_o), 64'd0);
        valid_i = 1'b1;
        set_pix(16'd17, 16'd0, 16'd0, 32'd0);
        tick();
        valid_i = 1'b0;
        chk("fill_reject", 64'(level_o), 64'd16);
        ack_i = 1'b1;
        tick();
        ack_i = 1'b0;
        valid_i = 1'b1;
        set_pix(16'd99, 16'd0, 16'd0, 32'd0);
        tick();
        valid_i = 1'b0;
        chk("full_pushpop", 64'(level_o), 64'd15);
        ack_i = 1'b1;
        run(60);
        ack_i = 1'b0;
        chk("fill_count", 64'(seen.size()), 64'd17);
        for (int i = 0; i < 17 && i < seen.size(); i++)
            chk("fill_order", 64'(seen[i]), 64'(i));

        // Push and pop together at level 8
        push_n(9, 100);
        ack_i = 1'b1;
        tick();
        ack_i = 1'b0;
        chk("mid_level_pre", 64'(level_o), 64'd8);
        valid_i = 1'b1;
        set_pix(16'd120, 16'd0, 16'd0, 32'd0);
        tick();
        valid_i = 1'b0;
        chk("mid_pushpop", 64'(level_o), 64'd8);
        ack_i = 1'b1;
        run(60);
        ack_i = 1'b0;

        // Flush with 5 queued and one awaiting ack
        push_n(6, 200);
        run(2);
        chk("fl_pre", 64'(level_o), 64'd5);
        base_cnt = seen.size();
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        chk("fl_level", 64'(level_o), 64'd0);
        chk("fl_busy", 64'(busy_o), 64'd1);
        run(3);
        ack_i = 1'b1;
        tick();
        ack_i = 1'b0;
        chk("fl_done", 64'(busy_o), 64'd0);
        run(5);
        chk("fl_nowrite", 64'(seen.size()), 64'(base_cnt));
`ifdef GFX256_PIXQ_STATS_EN
        chk("fl_drop", 64'(drop_count_o), 64'd5);
        chk("fl_pix", 64'(pix_count_o), 64'd29);
`endif

        // Reset while waiting for ack, then a stray ack
        push_n(1, 300);
        run(2);
        rst_ni = 1'b0;
        tick();
        rst_ni = 1'b1;
        ack_i = 1'b1;
        tick();
        ack_i = 1'b0;
        chk("rr_x", 64'(pixel_x_o), 64'd0);
        chk("rr_color", 64'(color_o), 64'd0);
        chk("rr_busy", 64'(busy_o), 64'd0);
        chk("rr_ready", 64'(ready_o), 64'd1);
        run(3);
        chk("rr_write", 64'(write_o), 64'd0);
`ifdef GFX256_PIXQ_STATS_EN
        chk("rr_pix", 64'(pix_count_o), 64'd0);
`endif

        // Random stream of 1000 pixels with random ack delay
        seen.delete();
        auto_ack = 1;
        acc = 0;
        cyc = 0;
        while (acc < 1000 && cyc < 30000) begin
            valid_i = ($urandom_range(0, 9) < 7);
            set_pix(16'($urandom), 16'($urandom), 16'($urandom), 32'($urandom));
            if (valid_i && ready_o) begin
                acc++;
                sent.push_back(pixel_x_i);
            end
            tick();
            cyc++;
        end
        valid_i = 1'b0;
        cyc = 0;
        while ((busy_o || ack_pend) && cyc < 2000) begin
            tick();
            cyc++;
        end
        chk("rnd_drain", 64'(busy_o), 64'd0);
        chk("rnd_writes", 64'(seen.size()), 64'd1000);
        mism = 0;
        for (int i = 0; i < sent.size() && i < seen.size(); i++)
            if (seen[i] !== sent[i]) mism++;
        chk("rnd_order", 64'(mism), 64'd0);
`ifdef GFX256_PIXQ_STATS_EN
        chk("rnd_pix", 64'(pix_count_o), 64'd1000);
`endif
        auto_ack = 0;
        ack_i = 1'b0;
        run(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/gfx256_pixel_queue.md
GFX256_PIXEL_QUEUE -- requirements
Module: gfx256_pixel_queue

Interface
REQ-001 SHALL have parameter point_width, default 16, coordinate/depth width, matching the renderer.
REQ-002 SHALL have parameter DEPTH, default 16, number of queue entries; power of two, 2..256.
REQ-003 SHALL have port clk_i  in  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_ni  in  1  reset, synchronous and active-low.
REQ-005 SHALL have port flush_i  in  1  discard all queued pixels not yet issued.
REQ-006 SHALL have ports pixel_x_i, pixel_y_i, pixel_z_i  in  point_width each  incoming pixel coordinates/depth.
REQ-007 SHALL have port color_i  in  32  incoming pixel color.
REQ-008 SHALL have port valid_i  in  1  upstream offers a pixel this cycle.
REQ-009 SHALL have port ready_o  out  1  queue accepts a pixel this cycle.
REQ-010 SHALL have ports pixel_x_o, pixel_y_o, pixel_z_o  out  point_width each  and color_o  out  32  pixel presented to the renderer.
REQ-011 SHALL have port write_o  out  1  one-cycle render request to the renderer's write_i.
REQ-012 SHALL have port ack_i  in  1  renderer completion pulse (renderer ack_o).
REQ-013 SHALL have ports level_o  out  $clog2(DEPTH)+1  entries held, and busy_o  out  1  queue non-empty or pixel in flight.

Function
REQ-014 SHALL accept a pixel on any edge where valid_i && ready_o, writing it at the tail.
REQ-015 SHALL drive ready_o = (level_o != DEPTH) from registered state only; a push while full SHALL be ignored even if a pop occurs the same cycle.
REQ-016 SHALL run a three-state FSM: IDLE, ISSUE, WAIT_ACK.
REQ-017 IDLE -> ISSUE when the queue is non-empty at a clock edge; head entry is popped into output registers on that edge.
REQ-018 In ISSUE, write_o SHALL be 1 for exactly one cycle; next state WAIT_ACK.
REQ-019 In WAIT_ACK, pixel_*_o and color_o SHALL stay stable; on ack_i, -> IDLE.
REQ-020 First-pixel latency: push at edge N -> write_o high in cycle after edge N+1 (2 cycles); back-to-back: write_o re-asserts 2 cycles after ack_i cycle.
REQ-021 ack_i outside WAIT_ACK SHALL be ignored.
REQ-022 Simultaneous push and pop SHALL leave level_o unchanged; pointers wrap modulo DEPTH.
REQ-023 flush_i SHALL set level_o to 0 and equalise pointers on the next edge; a pixel in ISSUE/WAIT_ACK SHALL complete normally; a push coincident with flush_i SHALL be discarded; flush_i takes priority over pop from IDLE.
REQ-024 busy_o = (level_o != 0) || state != IDLE.

Reset
REQ-025 On rst_ni low at an edge: state IDLE, pointers and level 0, write_o 0, pixel_*_o 0, color_o 0; ready_o 1 after reset.
REQ-026 Reset mid-transaction SHALL abandon the in-flight pixel; any late ack_i after reset SHALL be ignored.

Configuration
REQ-027 Macro GFX256_PIXQ_STATS_EN SHALL, when defined, add port pix_count_o  out  32  counting ack_i accepted in WAIT_ACK, cleared by reset only, wrapping at 2^32; and port drop_count_o  out  16  counting pixels discarded by flush_i (saturating).
REQ-028 Without GFX256_PIXQ_STATS_EN the ports and counters SHALL be absent and remaining behaviour identical.

Verification
REQ-029 Single pixel: push x=5,y=7,z=0x1234,color=0xFF00FF00 into empty queue -> write_o pulses 2 cycles later with those values; held until ack_i; busy_o falls cycle after ack.
REQ-030 Fill: DEPTH=16, push 17 pixels with renderer stalled (no ack) -> 16 stored plus 1 in flight... first accepted pixel issued, ready_o low when level_o=16; 18th push rejected; all emerge in order x=0..16.
REQ-031 Simultaneous push/pop at level 16 -> push refused; at level 8 -> level stays 8.
REQ-032 flush_i asserted with 5 queued and 1 in WAIT_ACK -> level_o=0 next cycle, in-flight pixel acked normally, no further write_o; drop_count_o=5 with GFX256_PIXQ_STATS_EN.
REQ-033 rst_ni low during WAIT_ACK, then stray ack_i -> outputs zero, state IDLE, no pix_count_o increment.
REQ-034 Stream 1000 random pixels with random ack delay 0..10 -> scoreboard order match, pix_count_o=1000, no write_o while in WAIT_ACK.
